// File: rtl/mc97_tx_feeder.sv
// MC97 TX feeder: pops one sample from the TX FIFO per frame request and presents it as a
// tagged 20-bit slot word, with prefill, underrun accounting and drain-on-stop.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | stream stopped; FIFO drained via fifo_flush
// PREFILL  | waiting for fifo_lvl >= ctl_thresh
// RUN      | one pop per frm_req; empty FIFO on a frame -> UNDERRUN
// UNDERRUN | single-cycle marker after an underrun, returns to PREFILL
module mc97_tx_feeder #(
  parameter int LVL_W     = 9,
  parameter int CNT_W     = 16,
  parameter int HOLD_LAST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      fifo_data,
  input  logic             fifo_empty,
  input  logic [LVL_W-1:0] fifo_lvl,
  output logic             fifo_re,
  output logic             fifo_flush,
  input  logic             frm_req,
  output logic [19:0]      slot_data,
  output logic             slot_valid,
  input  logic             ctl_run,
  input  logic [LVL_W-1:0] ctl_thresh,
  output logic [CNT_W-1:0] stat_underrun,
  input  logic             stat_underrun_clr,
  output logic [1:0]       stat_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFILL  = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] last;
  logic        pop;
  logic        urun;
  logic        drain_done;

  assign pop        = frm_req & (state == RUN) & ~fifo_empty & ctl_run;
  assign urun       = frm_req & (state == RUN) &  fifo_empty & ctl_run;
  assign fifo_re    = pop;
  assign stat_state = state;

  // The FIFO drops one word per flush cycle; stop on the cycle that removes the last word
  // so flush does not linger for a cycle against an already-empty FIFO.
  assign drain_done = fifo_flush & (fifo_lvl == LVL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fifo_flush <= 1'b0;
    end else begin
      fifo_flush <= 1'b0;
      if (!ctl_run) begin
        state      <= IDLE;
        fifo_flush <= ~fifo_empty & ~drain_done;
      end else begin
        case (state)
          IDLE:     state <= PREFILL;
          PREFILL:  if (fifo_lvl >= ctl_thresh) state <= RUN;
          RUN:      if (urun) state <= UNDERRUN;
          UNDERRUN: state <= PREFILL;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_data  <= 20'h0;
      slot_valid <= 1'b0;
      last       <= 16'h0;
    end else if (frm_req) begin
      if (pop) begin
        slot_data  <= {fifo_data, 4'h0};
        slot_valid <= 1'b1;
        last       <= fifo_data;
      end else if (urun) begin
        slot_data  <= (HOLD_LAST != 0) ? {last, 4'h0} : 20'h0;
        slot_valid <= 1'b0;
      end else begin
        slot_data  <= 20'h0;
        slot_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_underrun <= '0;
    end else if (stat_underrun_clr) begin
      stat_underrun <= '0;
    end else if (urun && (stat_underrun != {CNT_W{1'b1}})) begin
      stat_underrun <= stat_underrun + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc97_tx_feeder.sv
// Bench for mc97_tx_feeder: queue-based FIFO model, expected slot words scoreboarded per frame.
// A second instance (4-bit counter, HOLD_LAST=1) shares the stimulus for saturation/hold checks.
module tb_mc97_tx_feeder;

  typedef struct packed {
    logic [19:0] data;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic [8:0]  fifo_lvl;
  logic        frm_req;
  logic        ctl_run;
  logic [8:0]  ctl_thresh;
  logic        clr;

  logic        fifo_re, fifo_flush, slot_valid;
  logic [19:0] slot_data;
  logic [15:0] stat_underrun;
  logic [1:0]  stat_state;

  logic        re2, flush2, sv2;
  logic [19:0] sd2;
  logic [3:0]  stat2;
  logic [1:0]  st2;

  logic [15:0] fq[$];
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          re_seen = 0;
  int          flush_seen = 0;

  always #5 clk = ~clk;

  mc97_tx_feeder #(.LVL_W(9), .CNT_W(16), .HOLD_LAST(0)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_lvl(fifo_lvl), .fifo_re(fifo_re), .fifo_flush(fifo_flush), .frm_req(frm_req),
    .slot_data(slot_data), .slot_valid(slot_valid), .ctl_run(ctl_run),
    .ctl_thresh(ctl_thresh), .stat_underrun(stat_underrun),
    .stat_underrun_clr(clr), .stat_state(stat_state)
  );

  mc97_tx_feeder #(.LVL_W(9), .CNT_W(4), .HOLD_LAST(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_lvl(fifo_lvl), .fifo_re(re2), .fifo_flush(flush2), .frm_req(frm_req),
    .slot_data(sd2), .slot_valid(sv2), .ctl_run(ctl_run),
    .ctl_thresh(ctl_thresh), .stat_underrun(stat2),
    .stat_underrun_clr(clr), .stat_state(st2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 16'h0 : fq[0];
    fifo_lvl   = 9'(fq.size());
  endtask

  task automatic load(input logic [15:0] w);
    fq.push_back(w);
    upd_fifo();
  endtask

  task automatic step(input logic frm);
    logic r, f;
    exp_t e;
    frm_req = frm;
    #1;
    r = fifo_re;
    f = fifo_flush;
    if (r || f) check("re_flush_excl", {31'h0, r & f}, 32'h0);
    if (r) re_seen++;
    if (f) flush_seen++;
    @(posedge clk);
    #1;
    if ((r || f) && fq.size() > 0) void'(fq.pop_front());
    upd_fifo();
    if (frm) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("slot_data", {12'h0, slot_data}, {12'h0, e.data});
        check("slot_valid", {31'h0, slot_valid}, {31'h0, e.valid});
      end
    end
    @(negedge clk);
    frm_req = 1'b0;
  endtask

  task automatic frame(input logic [19:0] d, input logic v);
    exp_t e;
    e.data  = d;
    e.valid = v;
    exp_q.push_back(e);
    step(1'b1);
  endtask

  initial begin
    rst_n = 1'b0; frm_req = 1'b0; ctl_run = 1'b0; ctl_thresh = 9'd4; clr = 1'b0;
    upd_fifo();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0);
    check("rst_state", {30'h0, stat_state}, 32'd0);
    check("rst_slot_data", {12'h0, slot_data}, 32'h0);
    check("rst_slot_valid", {31'h0, slot_valid}, 32'h0);
    check("rst_flush", {31'h0, fifo_flush}, 32'h0);
    check("rst_underrun", {16'h0, stat_underrun}, 32'h0);

    // prefill to threshold 4, then pop through to an underrun
    ctl_run = 1'b1;
    step(1'b0);
    check("prefill_enter", {30'h0, stat_state}, 32'd1);
    load(16'h1234); load(16'h2222); load(16'h3333);
    re_seen = 0;
    repeat (3) frame(20'h0, 1'b0);
    check("prefill_hold", {30'h0, stat_state}, 32'd1);
    check("prefill_no_pop", re_seen, 32'd0);
    load(16'hBEEF);
    step(1'b0);
    check("prefill_to_run", {30'h0, stat_state}, 32'd2);
    frame(20'h12340, 1'b1);
    frame(20'h22220, 1'b1);
    frame(20'h33330, 1'b1);
    frame(20'hBEEF0, 1'b1);
    frame(20'h0, 1'b0);
    check("urun_state", {30'h0, stat_state}, 32'd3);
    check("urun_count", {16'h0, stat_underrun}, 32'd1);
    check("urun_hold_data", {12'h0, sd2}, 32'hBEEF0);
    check("urun_hold_valid", {31'h0, sv2}, 32'h0);
    step(1'b0);
    check("urun_to_prefill", {30'h0, stat_state}, 32'd1);

    // stop with 10 words queued: drain over exactly 10 flush cycles
    for (int i = 0; i < 10; i++) load(16'h0100 + 16'(i));
    step(1'b0);
    check("run_10w", {30'h0, stat_state}, 32'd2);
    ctl_run = 1'b0;
    re_seen = 0;
    step(1'b0);
    check("stop_state", {30'h0, stat_state}, 32'd0);
    check("stop_flush", {31'h0, fifo_flush}, 32'h1);
    flush_seen = 0;
    repeat (14) step(1'b0);
    check("drain_cycles", flush_seen, 32'd10);
    check("drain_no_pop", re_seen, 32'd0);
    check("drain_empty", fq.size(), 32'd0);
    check("drain_flush_off", {31'h0, fifo_flush}, 32'h0);
    frame(20'h0, 1'b0);

    // threshold met on a frame cycle: silence, no pop
    ctl_thresh = 9'd2;
    ctl_run = 1'b1;
    step(1'b0);
    check("c_prefill", {30'h0, stat_state}, 32'd1);
    load(16'hA001); load(16'hA002);
    re_seen = 0;
    frame(20'h0, 1'b0);
    check("c_thr_run", {30'h0, stat_state}, 32'd2);
    check("c_thr_no_pop", re_seen, 32'd0);
    check("c_thr_lvl", fq.size(), 32'd2);
    frame(20'hA0010, 1'b1);
    frame(20'hA0020, 1'b1);
    // underrun and clear together
    clr = 1'b1;
    frame(20'h0, 1'b0);
    clr = 1'b0;
    check("c_clr_count", {16'h0, stat_underrun}, 32'd0);
    check("c_clr_count2", {28'h0, stat2}, 32'd0);
    check("c_clr_state", {30'h0, stat_state}, 32'd3);
    step(1'b0);
    load(16'hB001); load(16'hB002);
    step(1'b0);
    check("c_fall_run", {30'h0, stat_state}, 32'd2);
    // ctl_run falls on a RUN frame: silence, no pop
    ctl_run = 1'b0;
    re_seen = 0;
    frame(20'h0, 1'b0);
    check("c_fall_no_pop", re_seen, 32'd0);
    check("c_fall_state", {30'h0, stat_state}, 32'd0);
    check("c_fall_count", {16'h0, stat_underrun}, 32'd0);
    repeat (4) step(1'b0);
    check("c_fall_drained", fq.size(), 32'd0);

    // thresh=0 leaves PREFILL with an empty FIFO; 20 underruns saturate the 4-bit counter
    ctl_thresh = 9'd0;
    ctl_run = 1'b1;
    step(1'b0);
    step(1'b0);
    check("t0_run", {30'h0, stat_state}, 32'd2);
    repeat (60) frame(20'h0, 1'b0);
    check("sat_count16", {16'h0, stat_underrun}, 32'd20);
    check("sat_count4", {28'h0, stat2}, 32'hF);

    // threshold above FIFO depth never reaches RUN
    ctl_run = 1'b0;
    step(1'b0);
    step(1'b0);
    ctl_thresh = 9'd300;
    ctl_run = 1'b1;
    step(1'b0);
    for (int i = 0; i < 20; i++) load(16'hC000 + 16'(i));
    repeat (3) step(1'b0);
    check("big_thr_prefill", {30'h0, stat_state}, 32'd1);
    ctl_thresh = 9'd1;
    step(1'b0);
    check("big_thr_run", {30'h0, stat_state}, 32'd2);

    // async reset mid-RUN with a frame request pending
    frm_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_re", {31'h0, fifo_re}, 32'h0);
    check("arst_state", {30'h0, stat_state}, 32'd0);
    check("arst_slot_data", {12'h0, slot_data}, 32'h0);
    check("arst_slot_valid", {31'h0, slot_valid}, 32'h0);
    check("arst_flush", {31'h0, fifo_flush}, 32'h0);
    check("arst_count", {16'h0, stat_underrun}, 32'h0);
    check("sb_leftover", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
